// File: rtl/sdram_write_burst_if.sv
// Signal bundle between the SDRAM write engine, the bus arbiter, the data FIFO and the SDRAM pins.
// master: the write engine; slave: the arbiter/FIFO/pin side.
interface sdram_write_burst_if #(
  parameter int DW     = 16,
  parameter int ROW_W  = 12,
  parameter int COL_W  = 9,
  parameter int BANK_W = 2,
  parameter int LEN_W  = 8
);
  logic                          wr_trig;
  logic [BANK_W+ROW_W+COL_W-1:0] wr_addr;
  logic [LEN_W-1:0]              wr_len;
  logic                          wr_en;
  logic                          flag_wr_ask;
  logic                          flag_wr_end;
  logic                          wr_done;
  logic                          wr_busy;
  logic                          wr_data_en;
  logic [DW-1:0]                 wr_data;
  logic [3:0]                    sdram_cmd;
  logic [ROW_W-1:0]              sdram_addr;
  logic [BANK_W-1:0]             sdram_bank;
  logic [DW-1:0]                 sdram_data;

  modport master (
    input  wr_trig, wr_addr, wr_len, wr_en, wr_data,
    output flag_wr_ask, flag_wr_end, wr_done, wr_busy, wr_data_en,
    output sdram_cmd, sdram_addr, sdram_bank, sdram_data
  );

  modport slave (
    output wr_trig, wr_addr, wr_len, wr_en, wr_data,
    input  flag_wr_ask, flag_wr_end, wr_done, wr_busy, wr_data_en,
    input  sdram_cmd, sdram_addr, sdram_bank, sdram_data
  );
endinterface

// File: rtl/sdram_write_burst.sv
// Multi-burst SDRAM write engine: ask/grant bus ownership, ACT/WRITE/PRE with tRCD/tWR/tRP gaps,
// row/bank crossing and preemption at burst boundaries. Commands appear one cycle after their state.
module sdram_write_burst #(
  parameter int DW     = 16,
  parameter int ROW_W  = 12,
  parameter int COL_W  = 9,
  parameter int BANK_W = 2,
  parameter int BURST  = 4,
  parameter int LEN_W  = 8,
  parameter int T_RCD  = 2,
  parameter int T_WR   = 2,
  parameter int T_RP   = 2
) (
  input  logic                sclk,
  input  logic                srst_n,
  sdram_write_burst_if.master bus
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int TMR_W  = 8;
  localparam int BR_W   = BANK_W + ROW_W;
  localparam int AW     = BANK_W + ROW_W + COL_W;
  localparam logic [ROW_W-1:0] PRE_ADDR = ROW_W'(1) << 10;

  typedef enum logic [2:0] {
    S_IDLE, S_ASK, S_ACT, S_RCD, S_WR, S_TWR, S_PRE, S_TRP
  } state_t;

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  tmr;
  logic [BEAT_W-1:0] beat;
  logic [BANK_W-1:0] bank_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [LEN_W-1:0]  cnt_q;

  logic              beat_last;
  logic [COL_W-1:0]  col_after;
  logic [LEN_W-1:0]  cnt_after;

  // Column/count as they stand once the current burst has been accounted for.
  assign beat_last = (beat == BEAT_W'(BURST - 1));
  assign col_after = (beat == '0) ? col_q + COL_W'(BURST) : col_q;
  assign cnt_after = (beat == '0) ? cnt_q - LEN_W'(1) : cnt_q;

  always_ff @(posedge sclk) begin
    if (!srst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.wr_trig && bus.wr_len != '0) state_nxt = S_ASK;
      S_ASK:  if (bus.wr_en) state_nxt = S_ACT;
      S_ACT:  state_nxt = (T_RCD > 1) ? S_RCD : S_WR;
      S_RCD:  if (tmr == TMR_W'(T_RCD - 2)) state_nxt = S_WR;
      S_WR:   if (beat_last && (cnt_after == '0 || col_after == '0 || !bus.wr_en))
                state_nxt = S_TWR;
      S_TWR:  if (tmr == TMR_W'(T_WR - 1)) state_nxt = S_PRE;
      S_PRE:  state_nxt = S_TRP;
      S_TRP:  if (tmr == TMR_W'(T_RP - 1)) begin
                if (cnt_q == '0)    state_nxt = S_IDLE;
                else if (!bus.wr_en) state_nxt = S_ASK;
                else                state_nxt = S_ACT;
              end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      tmr             <= '0;
      beat            <= '0;
      bank_q          <= '0;
      row_q           <= '0;
      col_q           <= '0;
      cnt_q           <= '0;
      bus.sdram_cmd   <= CMD_NOP;
      bus.sdram_addr  <= '0;
      bus.sdram_bank  <= '0;
      bus.sdram_data  <= '0;
      bus.flag_wr_ask <= 1'b0;
      bus.flag_wr_end <= 1'b0;
      bus.wr_done     <= 1'b0;
      bus.wr_busy     <= 1'b0;
      bus.wr_data_en  <= 1'b0;
    end else begin
      tmr  <= (state_nxt == state) ? tmr + TMR_W'(1) : '0;
      beat <= (state == S_WR && !beat_last) ? beat + BEAT_W'(1) : '0;

      if (state == S_IDLE && state_nxt == S_ASK) begin
        {bank_q, row_q} <= bus.wr_addr[AW-1:COL_W];
        col_q           <= bus.wr_addr[COL_W-1:0] & ~COL_W'(BURST - 1);
        cnt_q           <= bus.wr_len;
      end

      if (state == S_WR) begin
        col_q <= col_after;
        cnt_q <= cnt_after;
        // Row end: bump {bank,row} now so both a reopen and a post-preemption ACT see it.
        if (beat_last && col_after == '0)
          {bank_q, row_q} <= {bank_q, row_q} + BR_W'(1);
      end

      bus.sdram_cmd <= CMD_NOP;
      case (state)
        S_ACT: begin
          bus.sdram_cmd  <= CMD_ACT;
          bus.sdram_addr <= row_q;
          bus.sdram_bank <= bank_q;
        end
        S_WR: if (beat == '0) begin
          bus.sdram_cmd  <= CMD_WR;
          bus.sdram_addr <= ROW_W'(col_q);
          bus.sdram_bank <= bank_q;
        end
        S_PRE: begin
          bus.sdram_cmd  <= CMD_PRE;
          bus.sdram_addr <= PRE_ADDR;
        end
        default: ;
      endcase

      // Pop strobe leads the beat by one cycle so the registered data lines up with the WRITE.
      bus.wr_data_en  <= (state_nxt == S_WR);
      if (bus.wr_data_en) bus.sdram_data <= bus.wr_data;

      bus.flag_wr_ask <= (state_nxt == S_ASK);
      bus.flag_wr_end <= (state == S_TRP) && (state_nxt == S_IDLE || state_nxt == S_ASK);
      bus.wr_done     <= (state == S_TRP) && (state_nxt == S_IDLE);
      bus.wr_busy     <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_sdram_write_burst.sv
// Directed bench for sdram_write_burst: vector table of single requests plus hand sequences
// for ignored triggers, preemption and mid-burst reset.
`timescale 1ns/1ps
module tb_sdram_write_burst;
  localparam int DW = 16, ROW_W = 12, COL_W = 9, BANK_W = 2, BURST = 4, LEN_W = 8;
  localparam int T_RCD = 2, T_WR = 2, T_RP = 2;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_WR = 4'b0100, C_PRE = 4'b0010;

  logic sclk = 1'b0;
  logic srst_n;
  always #5 sclk = ~sclk;

  sdram_write_burst_if #(.DW(DW), .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W), .LEN_W(LEN_W)) bus ();

  sdram_write_burst #(
    .DW(DW), .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W), .BURST(BURST), .LEN_W(LEN_W),
    .T_RCD(T_RCD), .T_WR(T_WR), .T_RP(T_RP)
  ) dut (
    .sclk(sclk),
    .srst_n(srst_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [DW-1:0] pop_val = 16'hA000;
  assign bus.wr_data = pop_val;

  always @(posedge sclk) begin
    cyc <= cyc + 1;
    if (bus.wr_data_en) pop_val <= pop_val + 16'd1;
  end

  typedef struct { int cyc; logic [3:0] cmd; int addr; int bank; } ev_t;
  ev_t evq[$];
  logic [DW-1:0] exp_q[$];
  int den_cnt = 0, done_cnt = 0, end_cnt = 0, done_cyc = 0, data_err = 0, bad_cmd = 0;
  logic prev_den = 1'b0;

  always @(negedge sclk) begin
    ev_t e;
    e.cyc = cyc; e.cmd = bus.sdram_cmd; e.addr = int'(bus.sdram_addr); e.bank = int'(bus.sdram_bank);
    if (bus.sdram_cmd == C_ACT || bus.sdram_cmd == C_WR || bus.sdram_cmd == C_PRE) evq.push_back(e);
    else if (bus.sdram_cmd != C_NOP) bad_cmd++;
    if (prev_den && srst_n) begin
      if (exp_q.size() == 0 || bus.sdram_data !== exp_q[0]) data_err++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (bus.wr_data_en) begin den_cnt++; exp_q.push_back(bus.wr_data); end
    if (bus.wr_done) begin done_cnt++; done_cyc = cyc; end
    if (bus.flag_wr_end) end_cnt++;
    prev_den = bus.wr_data_en;
    if (!srst_n) begin exp_q.delete(); prev_den = 1'b0; end
  end

  int b_ev, b_den, b_done, b_end, b_err;
  task automatic mark();
    b_ev = evq.size(); b_den = den_cnt; b_done = done_cnt; b_end = end_cnt; b_err = data_err;
  endtask

  function automatic int ev_cnt(input logic [3:0] c);
    int n = 0;
    for (int i = b_ev; i < evq.size(); i++) if (evq[i].cmd == c) n++;
    return n;
  endfunction

  // k-th event of a command since the mark (k<0: last); f selects 0 cycle, 1 addr, 2 bank.
  function automatic int ev_f(input logic [3:0] c, input int k, input int f);
    int n = 0, r = -1;
    for (int i = b_ev; i < evq.size(); i++) if (evq[i].cmd == c) begin
      if (n == k || k < 0) r = i;
      n++;
    end
    if (r < 0) return -1;
    return (f == 0) ? evq[r].cyc : (f == 1) ? evq[r].addr : evq[r].bank;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge sclk); #2; end
  endtask

  task automatic start(input int bank, input int row, input int col, input int len, output int t0);
    bus.wr_addr = {BANK_W'(bank), ROW_W'(row), COL_W'(col)};
    bus.wr_len  = LEN_W'(len);
    bus.wr_trig = 1'b1;
    t0 = cyc;
    tick(1);
    bus.wr_trig = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == b_done && n < budget) begin tick(1); n++; end
  endtask

  typedef struct {
    int bank, row, col, len;
    int n_act, a0_row, a0_bank, al_row, al_bank;
    int n_wr, w0_col, wl_col, n_pre, lat;
  } vec_t;
  vec_t vt[6];

  initial begin
    int t0;
    string s;
    vt[0] = '{0, 12'h005, 9'h010, 1,  1, 12'h005, 0, 12'h005, 0,  1, 9'h010, 9'h010, 1, 13};
    vt[1] = '{0, 12'h000, 9'h000, 3,  1, 12'h000, 0, 12'h000, 0,  3, 9'h000, 9'h008, 1, 21};
    vt[2] = '{0, 12'h007, 9'h1FC, 2,  2, 12'h007, 0, 12'h008, 0,  2, 9'h1FC, 9'h000, 2, 24};
    vt[3] = '{1, 12'hFFF, 9'h1FC, 2,  2, 12'hFFF, 1, 12'h000, 2,  2, 9'h1FC, 9'h000, 2, 24};
    vt[4] = '{3, 12'hFFF, 9'h1FC, 2,  2, 12'hFFF, 3, 12'h000, 0,  2, 9'h1FC, 9'h000, 2, 24};
    vt[5] = '{2, 12'h123, 9'h013, 1,  1, 12'h123, 2, 12'h123, 2,  1, 9'h010, 9'h010, 1, 13};

    srst_n = 1'b0; bus.wr_trig = 1'b0; bus.wr_addr = '0; bus.wr_len = '0; bus.wr_en = 1'b1;
    tick(3);
    check("rst cmd", int'(bus.sdram_cmd), 4'b0111);
    check("rst addr/bank/data", int'({bus.sdram_addr, bus.sdram_bank, bus.sdram_data}), 0);
    check("rst flags", int'({bus.flag_wr_ask, bus.flag_wr_end, bus.wr_done, bus.wr_busy, bus.wr_data_en}), 0);
    srst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 6; i++) begin
      mark();
      start(vt[i].bank, vt[i].row, vt[i].col, vt[i].len, t0);
      wait_done(300);
      tick(3);
      s = $sformatf("v%0d", i);
      check({s, " n_act"}, ev_cnt(C_ACT), vt[i].n_act);
      check({s, " act0 row"}, ev_f(C_ACT, 0, 1), vt[i].a0_row);
      check({s, " act0 bank"}, ev_f(C_ACT, 0, 2), vt[i].a0_bank);
      check({s, " actL row"}, ev_f(C_ACT, -1, 1), vt[i].al_row);
      check({s, " actL bank"}, ev_f(C_ACT, -1, 2), vt[i].al_bank);
      check({s, " n_wr"}, ev_cnt(C_WR), vt[i].n_wr);
      check({s, " wr0 col"}, ev_f(C_WR, 0, 1), vt[i].w0_col);
      check({s, " wrL col"}, ev_f(C_WR, -1, 1), vt[i].wl_col);
      check({s, " n_pre"}, ev_cnt(C_PRE), vt[i].n_pre);
      check({s, " pre addr"}, ev_f(C_PRE, 0, 1), 12'h400);
      check({s, " act0 delay"}, ev_f(C_ACT, 0, 0) - t0, 3);
      check({s, " tRCD"}, ev_f(C_WR, 0, 0) - ev_f(C_ACT, 0, 0), T_RCD);
      check({s, " last beat to PRE"}, ev_f(C_PRE, -1, 0) - ev_f(C_WR, -1, 0), BURST - 1 + T_WR + 1);
      check({s, " PRE to done"}, done_cyc - ev_f(C_PRE, -1, 0), T_RP);
      check({s, " latency"}, done_cyc - t0, vt[i].lat);
      check({s, " done pulses"}, done_cnt - b_done, 1);
      check({s, " end pulses"}, end_cnt - b_end, 1);
      check({s, " beats"}, den_cnt - b_den, BURST * vt[i].len);
      check({s, " data errs"}, data_err - b_err, 0);
      check({s, " idle ask/busy"}, int'({bus.flag_wr_ask, bus.wr_busy}), 0);
      if (vt[i].n_act == 1)
        for (int k = 1; k < vt[i].n_wr; k++)
          check($sformatf("%s wr gap %0d", s, k), ev_f(C_WR, k, 0) - ev_f(C_WR, k - 1, 0), BURST);
    end

    // wr_trig with zero length in IDLE
    mark();
    start(1, 12'h050, 0, 0, t0);
    tick(8);
    check("len0 busy", int'(bus.wr_busy), 0);
    check("len0 cmds", evq.size() - b_ev, 0);

    // wr_trig while busy
    mark();
    start(0, 12'h040, 0, 1, t0);
    tick(3);
    bus.wr_addr = {BANK_W'(3), ROW_W'(12'h099), COL_W'(0)};
    bus.wr_len = LEN_W'(5);
    bus.wr_trig = 1'b1;
    tick(1);
    bus.wr_trig = 1'b0;
    wait_done(300);
    tick(12);
    check("busy-trig n_act", ev_cnt(C_ACT), 1);
    check("busy-trig row", ev_f(C_ACT, 0, 1), 12'h040);
    check("busy-trig done", done_cnt - b_done, 1);
    check("busy-trig beats", den_cnt - b_den, BURST);
    check("busy-trig busy", int'(bus.wr_busy), 0);

    // preemption: grant dropped during burst 2 of 4
    mark();
    start(0, 12'h020, 0, 4, t0);
    tick(8);
    bus.wr_en = 1'b0;
    for (int n = 0; n < 60 && end_cnt == b_end; n++) tick(1);
    tick(3);
    check("preempt end", end_cnt - b_end, 1);
    check("preempt no done", done_cnt - b_done, 0);
    check("preempt ask", int'(bus.flag_wr_ask), 1);
    check("preempt busy", int'(bus.wr_busy), 1);
    check("preempt n_wr", ev_cnt(C_WR), 2);
    check("preempt beats", den_cnt - b_den, 2 * BURST);
    check("preempt n_pre", ev_cnt(C_PRE), 1);
    bus.wr_en = 1'b1;
    wait_done(300);
    tick(3);
    check("resume n_act", ev_cnt(C_ACT), 2);
    check("resume row", ev_f(C_ACT, 1, 1), 12'h020);
    check("resume wr2 col", ev_f(C_WR, 2, 1), 9'h008);
    check("resume wr3 col", ev_f(C_WR, 3, 1), 9'h00C);
    check("resume done", done_cnt - b_done, 1);
    check("resume end", end_cnt - b_end, 2);
    check("resume beats", den_cnt - b_den, 4 * BURST);
    check("resume data errs", data_err - b_err, 0);

    // reset in the middle of a WRITE burst
    mark();
    start(0, 12'h003, 0, 3, t0);
    tick(5);
    srst_n = 1'b0;
    tick(1);
    check("midrst cmd", int'(bus.sdram_cmd), 4'b0111);
    check("midrst busy/den", int'({bus.wr_busy, bus.wr_data_en}), 0);
    check("midrst data", int'(bus.sdram_data), 0);
    srst_n = 1'b1;
    mark();
    tick(10);
    check("postrst quiet", evq.size() - b_ev, 0);
    check("postrst busy", int'(bus.wr_busy), 0);
    mark();
    start(0, 12'h009, 9'h020, 1, t0);
    wait_done(300);
    tick(3);
    check("rerun latency", done_cyc - t0, 13);
    check("rerun act row", ev_f(C_ACT, 0, 1), 12'h009);
    check("rerun wr col", ev_f(C_WR, 0, 1), 9'h020);
    check("rerun done", done_cnt - b_done, 1);
    check("rerun data errs", data_err - b_err, 0);
    check("illegal cmds", bad_cmd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500us");
    $fatal(1, "watchdog");
  end

endmodule
